// File: rtl/fifo_serializer_pkg.sv
// fifo_serializer_pkg: shared FSM state type, line-level constants and sizing helper.
// The PARITY state exists only when SERIALIZER_PARITY_EN is defined.
package fifo_serializer_pkg;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef SERIALIZER_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_serializer_if.sv
// fifo_serializer_if: FIFO read handshake plus serial-line status, grouped as one bundle.
// master = the serializer, slave = the FIFO/line side.
interface fifo_serializer_if #(
    parameter int DATA_WIDTH = 4
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_r_data;
    logic                  fifo_r_en;
    logic                  tx_out;
    logic                  busy;
    logic                  done;

    modport master (
        input  fifo_empty,
        input  fifo_r_data,
        output fifo_r_en,
        output tx_out,
        output busy,
        output done
    );

    modport slave (
        output fifo_empty,
        output fifo_r_data,
        input  fifo_r_en,
        input  tx_out,
        input  busy,
        input  done
    );
endinterface

// File: rtl/fifo_serializer_bit_timer.sv
// bit_timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each serial bit.
// Held at zero while clr is high, so every timed state starts with a fresh bit period.
module bit_timer
    import fifo_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_tick
);

    localparam int            TW   = cnt_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt;

    // Free-running bit period counter, wrapping at the last cycle of each bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + TW'(1);
        end
    end

    assign bit_tick = !clr && (cnt == LAST);

endmodule

// File: rtl/fifo_serializer.sv
// fifo_serializer: pops words from a synchronous FIFO and sends each as a
// start / LSB-first data / stop frame on tx_out.
// Optional even parity bit between data and stop when SERIALIZER_PARITY_EN is defined.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle (1), waiting for a non-empty FIFO
// S_POP    | fifo_r_en high for this single cycle
// S_LOAD   | FIFO read data valid, captured into the shift register
// S_START  | start bit (0) for CLKS_PER_BIT cycles
// S_DATA   | DATA_WIDTH payload bits, LSB first
// S_PARITY | even parity of the payload (parity build only)
// S_STOP   | stop bit (1); done on its last cycle, then POP or IDLE
module fifo_serializer
    import fifo_serializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_serializer_if.master bus
);

    localparam int               CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  tx_q;
    logic                  timer_clr;
    logic                  bit_tick;
`ifdef SERIALIZER_PARITY_EN
    logic                  parity_q;
`endif

    // Timed states only change on a tick, where the timer wraps to zero anyway;
    // holding it clear in the untimed states gives every frame a clean start bit.
    assign timer_clr = state inside {S_IDLE, S_POP, S_LOAD};

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .bit_tick(bit_tick)
    );

    // Frame sequencer; tx_q is loaded with the level of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            tx_q      <= IDLE_LEVEL;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= IDLE_LEVEL;
                    if (!bus.fifo_empty) begin
                        state <= S_POP;
                    end
                end
                S_POP: begin
                    state <= S_LOAD;
                end
                S_LOAD: begin
                    shift_reg <= bus.fifo_r_data;
`ifdef SERIALIZER_PARITY_EN
                    parity_q  <= ^bus.fifo_r_data;
`endif
                    bit_cnt   <= '0;
                    tx_q      <= START_BIT;
                    state     <= S_START;
                end
                S_START: begin
                    if (bit_tick) begin
                        tx_q      <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
`ifdef SERIALIZER_PARITY_EN
                            tx_q    <= parity_q;
                            state   <= S_PARITY;
`else
                            tx_q    <= STOP_BIT;
                            state   <= S_STOP;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                            tx_q      <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
`ifdef SERIALIZER_PARITY_EN
                S_PARITY: begin
                    if (bit_tick) begin
                        tx_q  <= STOP_BIT;
                        state <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_tick) begin
                        tx_q  <= IDLE_LEVEL;
                        state <= bus.fifo_empty ? S_IDLE : S_POP;
                    end
                end
                default: begin
                    tx_q  <= IDLE_LEVEL;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fifo_r_en = (state == S_POP);
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_STOP) && bit_tick;
    assign bus.tx_out    = tx_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: scoreboard bench for fifo_serializer.
// Two DUTs: CLKS_PER_BIT=4 (main) and CLKS_PER_BIT=1. Frame length and the
// parity slot follow SERIALIZER_PARITY_EN.
module tb_fifo_serializer;

    typedef struct {
        logic [3:0] data;
        int         cpb;
    } exp_t;

    logic clk;
    logic rst;

    int checks   = 0;
    int failures = 0;

    fifo_serializer_if #(.DATA_WIDTH(4)) bus0 ();
    fifo_serializer_if #(.DATA_WIDTH(4)) bus1 ();

    fifo_serializer #(.DATA_WIDTH(4), .CLKS_PER_BIT(4)) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    fifo_serializer #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    logic [3:0] fq0[$];
    logic [3:0] fq1[$];
    exp_t       exp_q0[$];
    exp_t       exp_q1[$];

    int  mon_cyc[2];
    bit  mon_active[2];
    int  wave_err[2];
    int  busy_err[2];
    int  extra_ren[2];
    int  cycle_no;
    int  ren_stamp[$];

    logic m_ren[2];
    logic m_tx[2];
    logic m_busy[2];
    logic m_done[2];

    assign m_ren[0]  = bus0.fifo_r_en;
    assign m_tx[0]   = bus0.tx_out;
    assign m_busy[0] = bus0.busy;
    assign m_done[0] = bus0.done;
    assign m_ren[1]  = bus1.fifo_r_en;
    assign m_tx[1]   = bus1.tx_out;
    assign m_busy[1] = bus1.busy;
    assign m_done[1] = bus1.done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int frame_len(input int cpb);
`ifdef SERIALIZER_PARITY_EN
        return 2 + 7 * cpb;
`else
        return 2 + 6 * cpb;
`endif
    endfunction

    // Expected line level c cycles into a frame (c=1 is the POP cycle).
    function automatic logic exp_tx(input logic [3:0] d, input int cpb, input int c);
        int slot;
        if (c <= 2) return 1'b1;
        slot = (c - 3) / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= 4) return d[slot-1];
`ifdef SERIALIZER_PARITY_EN
        if (slot == 5) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_word(input int k, input logic [3:0] d);
        if (k == 0) begin
            fq0.push_back(d);
            exp_q0.push_back('{d, 4});
        end else begin
            fq1.push_back(d);
            exp_q1.push_back('{d, 1});
        end
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while (((k == 0) ? exp_q0.size() : exp_q1.size()) != 0 || mon_active[k]) begin
            @(negedge clk);
            #1;
            n++;
            if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL wait_idle%0d actual=timeout required=idle within %0d cycles", k, budget);
                return;
            end
        end
        @(negedge clk);
        #1;
    endtask

    // Upstream FIFO model: registered read data one cycle after an accepted read.
    initial begin
        logic rd0, rd1;
        bus0.fifo_empty  = 1'b1;
        bus0.fifo_r_data = 4'h0;
        bus1.fifo_empty  = 1'b1;
        bus1.fifo_r_data = 4'h0;
        forever begin
            @(negedge clk);
            rd0 = bus0.fifo_r_en;
            rd1 = bus1.fifo_r_en;
            @(posedge clk);
            #1;
            if (rd0 === 1'b1 && fq0.size() > 0) bus0.fifo_r_data = fq0.pop_front();
            if (rd1 === 1'b1 && fq1.size() > 0) bus1.fifo_r_data = fq1.pop_front();
            bus0.fifo_empty = (fq0.size() == 0);
            bus1.fifo_empty = (fq1.size() == 0);
        end
    end

    // Monitor: records each frame from its fifo_r_en pulse and scores it on done.
    initial begin
        exp_t e;
        bit   have;
        cycle_no = 0;
        for (int k = 0; k < 2; k++) begin
            mon_cyc[k]    = 0;
            mon_active[k] = 1'b0;
            wave_err[k]   = 0;
            busy_err[k]   = 0;
            extra_ren[k]  = 0;
        end
        forever begin
            @(negedge clk);
            cycle_no++;
            for (int k = 0; k < 2; k++) begin
                e    = '{4'h0, 1};
                have = 1'b0;
                if (k == 0 && exp_q0.size() > 0) begin e = exp_q0[0]; have = 1'b1; end
                if (k == 1 && exp_q1.size() > 0) begin e = exp_q1[0]; have = 1'b1; end
                if (rst === 1'b1) begin
                    mon_active[k] = 1'b0;
                end else begin
                    if (m_ren[k] === 1'b1) begin
                        if (mon_active[k]) begin
                            extra_ren[k]++;
                        end else begin
                            mon_active[k] = 1'b1;
                            mon_cyc[k]    = 0;
                            wave_err[k]   = 0;
                            busy_err[k]   = 0;
                            extra_ren[k]  = 0;
                            if (k == 0) ren_stamp.push_back(cycle_no);
                        end
                    end
                    if (mon_active[k]) begin
                        mon_cyc[k]++;
                        if (!have || m_tx[k] !== exp_tx(e.data, e.cpb, mon_cyc[k])) wave_err[k]++;
                        if (m_busy[k] !== 1'b1) busy_err[k]++;
                        if (m_done[k] === 1'b1) begin
                            chk($sformatf("done_cycle%0d", k), mon_cyc[k], have ? frame_len(e.cpb) : -1);
                            chk($sformatf("frame_wave%0d", k), wave_err[k], 0);
                            chk($sformatf("frame_busy%0d", k), busy_err[k], 0);
                            chk($sformatf("single_ren%0d", k), extra_ren[k], 0);
                            if (k == 0 && exp_q0.size() > 0) e = exp_q0.pop_front();
                            if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
                            mon_active[k] = 1'b0;
                        end
                    end else if (m_done[k] === 1'b1) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_done%0d actual=1 required=0 (t=%0t)", k, $time);
                    end
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        int   n;
        exp_t dropped;
        rst = 1'b1;

        // Reset held with a word already waiting: nothing may leave the DUT.
        push_word(0, 4'b1010);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("rst_tx", bus0.tx_out, 1);
            chk("rst_ren", bus0.fifo_r_en, 0);
            chk("rst_busy", bus0.busy, 0);
            chk("rst_done", bus0.done, 0);
        end
        rst = 1'b0;
        wait_idle(0, 200);
        chk("idle_after_1010", bus0.busy, 0);

        // Back-to-back words with the FIFO never empty between them.
        ren_stamp.delete();
        push_word(0, 4'h3);
        push_word(0, 4'hC);
        wait_idle(0, 300);
        chk("b2b_ren_count", ren_stamp.size(), 2);
        if (ren_stamp.size() == 2) chk("b2b_gap", ren_stamp[1] - ren_stamp[0], frame_len(4));

        // Parity word (frame length follows the build).
        push_word(0, 4'b0111);
        wait_idle(0, 200);
        chk("idle_after_0111", bus0.busy, 0);

        // Reset during the third data bit aborts the frame.
        push_word(0, 4'h9);
        n = 0;
        while (!(mon_active[0] && mon_cyc[0] == 16) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reach", mon_cyc[0], 16);
        rst = 1'b1;
        if (exp_q0.size() > 0) dropped = exp_q0.pop_front();
        push_word(0, 4'h5);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("abort_tx", bus0.tx_out, 1);
            chk("abort_busy", bus0.busy, 0);
            chk("abort_done", bus0.done, 0);
            chk("abort_ren", bus0.fifo_r_en, 0);
        end
        rst = 1'b0;
        wait_idle(0, 200);
        chk("idle_after_abort", bus0.busy, 0);

        // One clock per bit.
        push_word(1, 4'hF);
        wait_idle(1, 100);
        chk("idle_after_cpb1", bus1.busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
